// File: rtl/imem_program_loader.sv
// Boot/debug loader: packs decoded instruction fields into RV32I words and
// writes them to consecutive IMEM words until an ecall closes the session.
module imem_program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              req_valid_i,
  output logic              req_ready,
  input  logic [3:0]        cls_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // IDLE: wait start | LOAD: accept request | WRITE: strobe word | DONE: ecall written | ERR: aborted
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic        is_sys;
  logic [31:0] enc;
  logic [2:0]  fault;
  logic        imm12_ok, imm13_ok, imm21_ok, accept;

  assign imm12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign imm13_ok = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign imm21_ok = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    enc   = '0;
    fault = 3'd0;
    case (cls_i)
      4'd0: enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      4'd1: begin
        enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
        if (!imm12_ok) fault = 3'd3;
      end
      4'd2: begin
        enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
        if (!imm12_ok) fault = 3'd3;
      end
      4'd3: begin
        enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
        if (!imm12_ok) fault = 3'd3;
      end
      4'd4: begin
        enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'b1100011};
        if (imm_i[0]) fault = 3'd2;
        else if (!imm13_ok) fault = 3'd3;
      end
      4'd5: begin
        enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
        if (imm_i[0]) fault = 3'd2;
        else if (!imm21_ok) fault = 3'd3;
      end
      4'd6: begin
        enc = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
        if (!imm12_ok) fault = 3'd3;
      end
      4'd7: enc = {imm_i[31:12], rd_i, 7'b0110111};
      4'd8: enc = 32'h0000_0073;
      default: fault = 3'd1;
    endcase
  end

  assign accept    = (state == LOAD) && req_valid_i && !start_i;
  assign req_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == WRITE);
  // A restart or reset landing on the write cycle must kill the strobe now.
  assign imem_we   = (state == WRITE) && !start_i && !rst_i;

  always_comb begin
    state_nx = state;
    if (start_i) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD:    if (accept) state_nx = (fault == 3'd0) ? WRITE : ERR;
        WRITE: begin
          if (is_sys)                        state_nx = DONE;
          else if (imem_addr == LAST_ADDR)   state_nx = ERR;
          else                               state_nx = LOAD;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      is_sys     <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      state <= state_nx;
      if (start_i) begin
        imem_addr  <= base_addr_i;
        imem_wdata <= '0;
        count      <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        err_code   <= 3'd0;
      end else if (accept) begin
        if (fault == 3'd0) begin
          imem_wdata <= enc;
          is_sys     <= (cls_i == 4'd8);
        end else begin
          err      <= 1'b1;
          err_code <= fault;
        end
      end else if (state == WRITE) begin
        count <= count + 1'b1;
        if (is_sys) begin
          done <= 1'b1;
        end else if (imem_addr == LAST_ADDR) begin
          err      <= 1'b1;
          err_code <= 3'd4;
        end else begin
          imem_addr <= imem_addr + 1'b1;
        end
      end
    end
  end

endmodule
